// File: rtl/flit_pkg.sv
// Shared definitions for the data-cache request flit path: flit/ctrl widths,
// ctrl tag encodings, the stored entry layout and the tag-sequence tracker states.
package flit_pkg;

  localparam int FLIT_W  = 16;
  localparam int CTRL_W  = 2;
  localparam int ENTRY_W = CTRL_W + FLIT_W;

  localparam logic [CTRL_W-1:0] CTRL_IDLE = 2'b00;
  localparam logic [CTRL_W-1:0] CTRL_HEAD = 2'b01;
  localparam logic [CTRL_W-1:0] CTRL_BODY = 2'b10;
  localparam logic [CTRL_W-1:0] CTRL_TAIL = 2'b11;

  // One stored flit: ctrl tag in the upper bits, payload below.
  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [FLIT_W-1:0] flit;
  } flit_entry_t;

  // Expected next tag for the optional tag-sequence tracker.
  typedef enum logic [1:0] {
    EXP_HEAD = 2'd0,
    EXP_BODY = 2'd1,
    EXP_TAIL = 2'd2
  } proto_state_e;

endpackage

// File: rtl/flit_ram.sv
// Flit storage: DEPTH x 18-bit register array, synchronous write,
// asynchronous read. Contents are not reset; the pointers decide validity.
module flit_ram
  import flit_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [ENTRY_W-1:0] rdata
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];

  // Write one entry per cycle when enabled.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/dc_req_flit_fifo.sv
// Store-and-forward flit buffer between the dcache request serializer and the
// ring injection port. A packet's flits are offered downstream only once its
// tail is stored; since storage is strictly FIFO, pkt_cnt != 0 guarantees the
// head entry belongs to a complete packet.
// Optional build macro DC_REQ_FLIT_PROTO_CHECK_EN adds a sticky head/body/tail
// tag-sequence checker driving proto_err; without it proto_err is tied low.
//
// Handshakes: input side - a flit is taken when v_flit_in && fifo_rdy and its
// tag is not idle; fifo_rdy is a pure register decode. Output side - a flit
// leaves when v_flit_out && flit_out_ack; ack without valid is ignored.
module dc_req_flit_fifo
  import flit_pkg::*;
#(
  parameter int DEPTH  = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       flit_in,
  input  logic [1:0]        ctrl_in,
  input  logic              v_flit_in,
  output logic              fifo_rdy,
  output logic [15:0]       flit_out,
  output logic [1:0]        ctrl_out,
  output logic              v_flit_out,
  input  logic              flit_out_ack,
  output logic [ADDR_W:0]   occupancy,
  output logic [ADDR_W:0]   pkt_cnt,
  output logic              proto_err
);

  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   occ_q, occ_d;
  logic [ADDR_W:0]   pkt_q, pkt_d;

  logic              push, pop, push_tail, pop_tail;
  flit_entry_t       wr_entry;
  flit_entry_t       rd_entry;
  logic [ENTRY_W-1:0] rd_raw;

  assign fifo_rdy   = (occ_q != FULL_CNT);
  assign v_flit_out = (pkt_q != '0);
  assign push       = v_flit_in && fifo_rdy && (ctrl_in != CTRL_IDLE);
  assign pop        = v_flit_out && flit_out_ack;

  assign wr_entry   = '{ctrl: ctrl_in, flit: flit_in};
  assign rd_entry   = flit_entry_t'(rd_raw);
  assign push_tail  = push && (ctrl_in == CTRL_TAIL);
  assign pop_tail   = pop && (rd_entry.ctrl == CTRL_TAIL);

  flit_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (wr_entry),
    .raddr (rd_ptr_q),
    .rdata (rd_raw)
  );

  // Head-of-queue view, zeroed whenever no complete packet is available.
  always_comb begin
    flit_out = '0;
    ctrl_out = '0;
    if (v_flit_out) begin
      flit_out = rd_entry.flit;
      ctrl_out = rd_entry.ctrl;
    end
  end

  // Next pointer and counter values from the push/pop decisions.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    pkt_d    = pkt_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (push && !pop)      occ_d = occ_q + CNT_ONE;
    else if (pop && !push) occ_d = occ_q - CNT_ONE;
    if (push_tail && !pop_tail)      pkt_d = pkt_q + CNT_ONE;
    else if (pop_tail && !push_tail) pkt_d = pkt_q - CNT_ONE;
  end

  // Pointer and counter registers; reset discards everything including partial packets.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      pkt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      pkt_q    <= pkt_d;
    end
  end

  assign occupancy = occ_q;
  assign pkt_cnt   = pkt_q;

`ifdef DC_REQ_FLIT_PROTO_CHECK_EN
  proto_state_e proto_state_q, proto_state_d;
  logic         proto_err_q, proto_err_d;
  logic         drop;

  // Any valid write that is not stored counts as a protocol violation.
  assign drop = v_flit_in && !push;

  // Tracker: advance on every push; a wrong tag flags an error and resyncs to the tag seen.
  always_comb begin
    proto_state_d = proto_state_q;
    proto_err_d   = proto_err_q;
    if (drop) proto_err_d = 1'b1;
    if (push) begin
      unique case (proto_state_q)
        EXP_HEAD: if (ctrl_in != CTRL_HEAD) proto_err_d = 1'b1;
        EXP_BODY: if (ctrl_in != CTRL_BODY) proto_err_d = 1'b1;
        EXP_TAIL: if (ctrl_in != CTRL_TAIL) proto_err_d = 1'b1;
        default:  proto_err_d = 1'b1;
      endcase
      unique case (ctrl_in)
        CTRL_HEAD: proto_state_d = EXP_BODY;
        CTRL_BODY: proto_state_d = EXP_TAIL;
        default:   proto_state_d = EXP_HEAD;
      endcase
    end
  end

  // Tracker state and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      proto_state_q <= EXP_HEAD;
      proto_err_q   <= 1'b0;
    end else begin
      proto_state_q <= proto_state_d;
      proto_err_q   <= proto_err_d;
    end
  end

  assign proto_err = proto_err_q;
`else
  assign proto_err = 1'b0;
`endif

endmodule

// File: doc/dc_req_flit_fifo.md
Name: dc_req_flit_fifo

Overview:
Packet-aware flit buffer directly downstream of the data-cache request serializer. It accepts 16-bit flits with 2-bit ctrl tags (head, body, tail) and returns the ready signal the serializer waits on. It forwards flits to the ring-network injection port in store-and-forward fashion: no flit of a packet leaves until that packet's tail has been written.

Parameters:
DEPTH, 8, flit entries; power of two, minimum 4, so one 3-flit packet always fits.
ADDR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
flit_in  input  16  flit from serializer
ctrl_in  input  2  01 head, 10 body, 11 tail, 00 invalid
v_flit_in  input  1  flit_in/ctrl_in valid
fifo_rdy  output  1  space for one flit; feeds serializer's fifo-ready input
flit_out  output  16  flit to ring injection port
ctrl_out  output  2  ctrl tag of flit_out
v_flit_out  output  1  flit_out valid
flit_out_ack  input  1  ring accepts flit_out this cycle
occupancy  output  ADDR_W+1  flits stored
pkt_cnt  output  ADDR_W+1  complete packets (tails) stored
proto_err  output  1  sticky tag-sequence error (optional feature)

Behaviour:
- Reset (rst high at posedge): pointers, occupancy and pkt_cnt go to 0; fifo_rdy=1, v_flit_out=0, proto_err=0. Storage array is not reset. rst mid-packet discards all contents, including partial packets.
- fifo_rdy = (occupancy != DEPTH), decoded from registers; it has no combinational path from any input.
- Push = v_flit_in && fifo_rdy && ctrl_in != 2'b00. On push, {ctrl_in, flit_in} is written at wr_ptr and wr_ptr wraps modulo DEPTH.
- v_flit_in with ctrl_in==00 is dropped. v_flit_in while fifo_rdy==0 is dropped. Neither changes state.
- v_flit_out = (pkt_cnt != 0). When pkt_cnt is nonzero, the entry at rd_ptr belongs to a complete packet, because storage is strictly FIFO.
- flit_out and ctrl_out show the entry at rd_ptr combinationally. Both are forced to 0 while v_flit_out==0.
- Pop = v_flit_out && flit_out_ack. rd_ptr advances with wrap. ack while v_flit_out==0 is ignored.
- occupancy: +1 on push only, -1 on pop only, unchanged on push and pop in the same cycle.
- pkt_cnt: +1 on a push with ctrl 11, -1 on a pop with ctrl 11, unchanged when both happen in the same cycle.
- Latency: a tail pushed at edge N raises v_flit_out after edge N, so the head is visible in cycle N+1. Each pop takes 1 cycle; 3 back-to-back acks drain one packet.
- Full while the pushed packet is incomplete (occupancy==DEPTH, pkt_cnt==0) cannot arise from a well-formed 3-flit source with DEPTH>=4 and ring acks present. It is not detected.
- Simultaneous push and pop while full: fifo_rdy is 0, so only the pop occurs; fifo_rdy returns to 1 the next cycle.

Optional Feature:
Macro DC_REQ_FLIT_PROTO_CHECK_EN.
- Defined: a 3-state tracker (EXP_HEAD, EXP_BODY, EXP_TAIL) advances on every push.
  - Transitions: EXP_HEAD --01--> EXP_BODY --10--> EXP_TAIL --11--> EXP_HEAD.
  - Any other tag on push sets proto_err=1 (sticky until rst). The flit is still stored, and the tracker resyncs: tag 01 goes to EXP_BODY, tag 11 goes to EXP_HEAD, tag 10 goes to EXP_TAIL.
  - Dropped writes (tag 00, or v_flit_in while not ready) also set proto_err.
- Undefined: no tracker is built, and proto_err is tied to 0.

Decomposition:
- Package flit_pkg holds:
  - FLIT_W=16 and CTRL_W=2;
  - ctrl constants CTRL_IDLE=2'b00, CTRL_HEAD=2'b01, CTRL_BODY=2'b10, CTRL_TAIL=2'b11;
  - typedef flit_entry_t = {ctrl, flit} (18 bits).
- One sub-module, flit_ram: DEPTH x 18 register array, synchronous write, asynchronous read. Pointer and counter logic stay in the top module.

Test Plan:
- Push head 0x1111/01, body 0x2222/10, tail 0x3333/11 on consecutive cycles, with ack held high. v_flit_out rises the cycle after the tail. Out appears in order 0x1111/01, 0x2222/10, 0x3333/11. pkt_cnt goes 1 then 0.
- Push head and body only, then hold for 10 cycles. v_flit_out stays 0 and occupancy=2. Push the tail: v_flit_out=1 the next cycle.
- DEPTH=8, ack=0, push 3 packets (9 attempted flits). fifo_rdy falls after the 8th push. The 9th flit is dropped and occupancy=8. One ack: fifo_rdy=1 the next cycle.
- Steady state with one packet stored, pushing tail 11 and popping tail 11 in the same cycle. occupancy and pkt_cnt are unchanged. Pointers wrap correctly across DEPTH.
- With DC_REQ_FLIT_PROTO_CHECK_EN defined, push sequence 01,11. proto_err=1 after the 2nd push and stays 1 until rst. With the macro undefined, proto_err is always 0.
- rst asserted mid-drain of a 2-packet load. Next cycle: occupancy=0, pkt_cnt=0, v_flit_out=0, fifo_rdy=1, flit_out=0.
